// File: rtl/sram_arbiter_pkg.sv
// Shared core defines for the SRAM arbiter: bus widths, size codes, master IDs,
// the request payload struct and the arbiter FSM state type.
package sram_arbiter_pkg;

  localparam int unsigned BUS_WIDTH      = 32;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned RAM_MASK_WIDTH = 4;

  localparam logic [1:0] SIZE_1B = 2'd0;
  localparam logic [1:0] SIZE_2B = 2'd1;
  localparam logic [1:0] SIZE_4B = 2'd2;

  localparam logic MID_M0 = 1'b0;  // instruction fetch
  localparam logic MID_M1 = 1'b1;  // load/store

  typedef struct packed {
    logic                      we;
    logic [1:0]                size;
    logic [BUS_WIDTH-1:0]      addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [RAM_MASK_WIDTH-1:0] wem;
  } sram_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_arb_idfifo.sv
// Outstanding-request ID FIFO: records which master owns each accepted request
// so responses can be routed back in order. DEPTH must be a power of two.
module sram_arb_idfifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter onto a shared SRAM bus with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin; default is fixed priority (m1 over m0).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned OUTST_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_req,
  input  logic                      m0_we,
  input  logic [1:0]                m0_size,
  input  logic [BUS_WIDTH-1:0]      m0_addr,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  input  logic [RAM_MASK_WIDTH-1:0] m0_wem,
  output logic                      m0_addr_ok,
  output logic                      m0_data_ok,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_we,
  input  logic [1:0]                m1_size,
  input  logic [BUS_WIDTH-1:0]      m1_addr,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  input  logic [RAM_MASK_WIDTH-1:0] m1_wem,
  output logic                      m1_addr_ok,
  output logic                      m1_data_ok,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  output logic                      s_req,
  output logic                      s_we,
  output logic [1:0]                s_size,
  output logic [BUS_WIDTH-1:0]      s_addr,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  output logic [RAM_MASK_WIDTH-1:0] s_wem,
  input  logic                      s_addr_ok,
  input  logic                      s_data_ok,
  input  logic [DATA_WIDTH-1:0]     s_rdata,
  output logic                      arb_err
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_lock_id;
  logic       r_arb_err;
  logic       w_gnt;
  logic       w_gnt_req;
  logic       w_s_req;
  logic       w_accept;
  logic       w_full;
  logic       w_empty;
  logic       w_head;
  logic       w_pop;
  sram_req_t  w_m0_fields;
  sram_req_t  w_m1_fields;
  sram_req_t  w_s_fields;
`ifdef SRAM_ARB_RR_EN
  logic       r_rr_ptr;
`endif

  assign w_m0_fields = '{we: m0_we, size: m0_size, addr: m0_addr, wdata: m0_wdata, wem: m0_wem};
  assign w_m1_fields = '{we: m1_we, size: m1_size, addr: m1_addr, wdata: m1_wdata, wem: m1_wem};

  // Grant selection and next state; LOCK pins the grant until acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = MID_M0;
    if (r_state == ST_LOCK) begin
      w_gnt = r_lock_id;
    end else if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
      w_gnt = r_rr_ptr;
`else
      w_gnt = MID_M1;
`endif
    end else if (m1_req) begin
      w_gnt = MID_M1;
    end
    w_gnt_req = (w_gnt == MID_M1) ? m1_req : m0_req;
    w_s_req   = !rst && w_gnt_req && !w_full;
    w_accept  = w_s_req && s_addr_ok;
    case (r_state)
      ST_IDLE: if (w_s_req && !s_addr_ok) w_state_nxt = ST_LOCK;
      ST_LOCK: if (!w_gnt_req || w_accept) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lock_id <= MID_M0;
      r_arb_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) r_lock_id <= w_gnt;
      if (s_data_ok && w_empty) r_arb_err <= 1'b1;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= MID_M0;
    end else if (w_accept) begin
      r_rr_ptr <= ~w_gnt;
    end
  end
`endif

  assign w_pop = s_data_ok && !w_empty;

  sram_arb_idfifo #(
    .DEPTH (OUTST_DEPTH),
    .W     (1)
  ) u_idfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .pop   (w_pop),
    .din   (w_gnt),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign w_s_fields = (w_gnt == MID_M1) ? w_m1_fields : w_m0_fields;
  assign s_req      = w_s_req;
  assign s_we       = w_s_fields.we;
  assign s_size     = w_s_fields.size;
  assign s_addr     = w_s_fields.addr;
  assign s_wdata    = w_s_fields.wdata;
  assign s_wem      = w_s_fields.wem;

  assign m0_addr_ok = w_accept && (w_gnt == MID_M0);
  assign m1_addr_ok = w_accept && (w_gnt == MID_M1);
  assign m0_data_ok = !rst && w_pop && (w_head == MID_M0);
  assign m1_data_ok = !rst && w_pop && (w_head == MID_M1);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign arb_err    = r_arb_err;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (default OUTST_DEPTH=2).
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      m0_req, m0_we, m1_req, m1_we;
  logic [1:0]                m0_size, m1_size;
  logic [BUS_WIDTH-1:0]      m0_addr, m1_addr;
  logic [DATA_WIDTH-1:0]     m0_wdata, m1_wdata;
  logic [RAM_MASK_WIDTH-1:0] m0_wem, m1_wem;
  logic                      m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [DATA_WIDTH-1:0]     m0_rdata, m1_rdata;
  logic                      s_req, s_we;
  logic [1:0]                s_size;
  logic [BUS_WIDTH-1:0]      s_addr;
  logic [DATA_WIDTH-1:0]     s_wdata;
  logic [RAM_MASK_WIDTH-1:0] s_wem;
  logic                      s_addr_ok, s_data_ok;
  logic [DATA_WIDTH-1:0]     s_rdata;
  logic                      arb_err;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  sram_arbiter u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wem(m0_wem), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wem(m1_wem), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_size(s_size), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wem(s_wem), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata), .arb_err(arb_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_size = SIZE_4B; m0_addr = 32'h0000_1000;
    m0_wdata = 32'h0; m0_wem = 4'h0;
    m1_req = 1'b0; m1_we = 1'b1; m1_size = SIZE_2B; m1_addr = 32'h0000_2000;
    m1_wdata = 32'h1234_5678; m1_wem = 4'h3;
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_s_req", s_req, 0);
    check_eq("rst_m0_addr_ok", m0_addr_ok, 0);
    check_eq("rst_m0_data_ok", m0_data_ok, 0);
    check_eq("rst_m1_data_ok", m1_data_ok, 0);
    check_eq("rst_arb_err", arb_err, 0);
    m0_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0; rst = 1'b0;
    tick();

`ifndef SRAM_ARB_RR_EN
    // Fixed priority: m1 wins every cycle while both request.
    m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1;
    #1;
    check_eq("fp_s_req", s_req, 1);
    check_eq("fp_m1_ok_0", m1_addr_ok, 1);
    check_eq("fp_m0_ok_0", m0_addr_ok, 0);
    check_eq("fp_s_addr", s_addr, 32'h2000);
    check_eq("fp_s_we", s_we, 1);
    check_eq("fp_s_wem", s_wem, 4'h3);
    tick();
    s_data_ok = 1'b1; s_rdata = 32'h0000_0011;
    for (int i = 1; i < 4; i++) begin
      #1;
      check_eq($sformatf("fp_m1_ok_%0d", i), m1_addr_ok, 1);
      check_eq($sformatf("fp_m0_ok_%0d", i), m0_addr_ok, 0);
      check_eq($sformatf("fp_m1_dok_%0d", i), m1_data_ok, 1);
      check_eq($sformatf("fp_m0_dok_%0d", i), m0_data_ok, 0);
      tick();
    end
    m1_req = 1'b0;
    #1;
    check_eq("fp_m0_after_drop", m0_addr_ok, 1);
    check_eq("fp_s_addr_m0", s_addr, 32'h1000);
    check_eq("fp_m1_dok_last", m1_data_ok, 1);
    tick();
`else
    // Round-robin: acceptances alternate starting with m0.
    m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data_ok = (i > 0);
      #1;
      check_eq($sformatf("rr_m0_ok_%0d", i), m0_addr_ok, (i % 2) == 0);
      check_eq($sformatf("rr_m1_ok_%0d", i), m1_addr_ok, (i % 2) == 1);
      tick();
    end
`endif
    // Drain the single remaining entry.
    m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    #1;
`ifndef SRAM_ARB_RR_EN
    check_eq("drain_m0_dok", m0_data_ok, 1);
`else
    check_eq("drain_m1_dok", m1_data_ok, 1);
`endif
    check_eq("drain_s_req", s_req, 0);
    tick();
    s_data_ok = 1'b0;

    // Stall holds the m0 grant even when m1 arrives.
    m0_req = 1'b1; s_addr_ok = 1'b0;
    #1;
    check_eq("lk_s_req", s_req, 1);
    check_eq("lk_s_addr_0", s_addr, 32'h1000);
    check_eq("lk_m0_ok_0", m0_addr_ok, 0);
    tick();
    m1_req = 1'b1;
    for (int i = 1; i < 3; i++) begin
      #1;
      check_eq($sformatf("lk_s_addr_%0d", i), s_addr, 32'h1000);
      check_eq($sformatf("lk_m1_ok_%0d", i), m1_addr_ok, 0);
      tick();
    end
    s_addr_ok = 1'b1;
    #1;
    check_eq("lk_m0_accept", m0_addr_ok, 1);
    check_eq("lk_m1_not", m1_addr_ok, 0);
    check_eq("lk_s_addr_3", s_addr, 32'h1000);
    tick();
    m0_req = 1'b0;
    #1;
    check_eq("lk_m1_accept", m1_addr_ok, 1);
    check_eq("lk_s_addr_m1", s_addr, 32'h2000);
    tick();

    // FIFO full: blocked even while a pop happens.
    m0_req = 1'b1; m1_req = 1'b0; s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("full_s_req", s_req, 0);
    check_eq("full_m0_ok", m0_addr_ok, 0);
    check_eq("full_m0_dok", m0_data_ok, 1);
    check_eq("full_m1_dok", m1_data_ok, 0);
    check_eq("full_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    tick();
    m0_req = 1'b0; s_rdata = 32'hCAFE_F00D;
    #1;
    check_eq("pop2_m1_dok", m1_data_ok, 1);
    check_eq("pop2_m0_dok", m0_data_ok, 0);
    check_eq("pop2_m1_rdata", m1_rdata, 32'hCAFE_F00D);
    check_eq("pop2_m0_rdata", m0_rdata, 32'hCAFE_F00D);
    tick();
    s_data_ok = 1'b0; s_addr_ok = 1'b0;

    // Locked master withdraws: s_req drops, back to IDLE next cycle.
    m0_req = 1'b1;
    tick();
    m0_req = 1'b0; m1_req = 1'b1;
    #1;
    check_eq("wd_s_req", s_req, 0);
    check_eq("wd_m1_ok", m1_addr_ok, 0);
    tick();
    s_addr_ok = 1'b1;
    #1;
    check_eq("wd_idle_s_req", s_req, 1);
    check_eq("wd_idle_m1_ok", m1_addr_ok, 1);
    check_eq("wd_idle_s_addr", s_addr, 32'h2000);
    tick();
    m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    #1;
    check_eq("wd_m1_dok", m1_data_ok, 1);
    tick();
    s_data_ok = 1'b0;
    #1;
    check_eq("pre_err_clear", arb_err, 0);

    // Response with nothing outstanding.
    s_data_ok = 1'b1;
    #1;
    check_eq("err_m0_dok", m0_data_ok, 0);
    check_eq("err_m1_dok", m1_data_ok, 0);
    tick();
    s_data_ok = 1'b0;
    #1;
    check_eq("err_set", arb_err, 1);
    repeat (3) tick();
    check_eq("err_sticky", arb_err, 1);

    // Reset with two outstanding requests.
    m0_req = 1'b1; s_addr_ok = 1'b1;
    tick();
    m0_req = 1'b0; m1_req = 1'b1;
    tick();
    m1_req = 1'b0; s_addr_ok = 1'b0;
    rst = 1'b1; m0_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    #1;
    check_eq("rst2_s_req", s_req, 0);
    check_eq("rst2_m0_ok", m0_addr_ok, 0);
    check_eq("rst2_m0_dok", m0_data_ok, 0);
    check_eq("rst2_m1_dok", m1_data_ok, 0);
    check_eq("rst2_arb_err", arb_err, 0);
    tick();
    rst = 1'b0; m0_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    tick();
    s_data_ok = 1'b1;
    #1;
    check_eq("post_rst_m0_dok", m0_data_ok, 0);
    check_eq("post_rst_m1_dok", m1_data_ok, 0);
    tick();
    s_data_ok = 1'b0;
    #1;
    check_eq("post_rst_err", arb_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
